// File: rtl/fifo_rd_burst.sv
// ---------------------------------------------------------------------------
// fifo_rd_burst
//   Read-side burst consumer for an async FIFO. It runs entirely in the read
//   clock domain. A command asks for cmd_len+1 words. The block pops exactly
//   that many words from a first-word-fall-through FIFO. It then presents
//   them on a valid/ready stream and marks the final beat with out_last.
//
//   A 2-entry skid buffer sits between the FIFO and the stream. Because of
//   it, rd_inc depends only on registered state and rd_empty, never on
//   out_ready, and the block still sustains one word per cycle.
//
// Ports
//   rd_clk, rd_rst      read clock, asynchronous active-low reset
//   rd_data, rd_empty   FIFO head word (FWFT) and empty flag
//   rd_inc              pop strobe; the FIFO advances on the edge where it is 1
//   cmd_valid/ready     burst command handshake
//   cmd_len             burst length minus one
//   out_valid/ready     output stream handshake
//   out_data, out_last  stream word and last-beat marker
//   busy                high from command accept until the last beat is taken
// ---------------------------------------------------------------------------
module fifo_rd_burst #(
    parameter int DSIZE  = 8,
    parameter int BLEN_W = 4
) (
    input  logic              rd_clk,
    input  logic              rd_rst,
    input  logic [DSIZE-1:0]  rd_data,
    input  logic              rd_empty,
    output logic              rd_inc,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [BLEN_W-1:0] cmd_len,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DSIZE-1:0]  out_data,
    output logic              out_last,
    output logic              busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2
    } state_t;

    localparam logic [BLEN_W:0] REM_ONE = (BLEN_W+1)'(1);

    state_t            state_q;
    // One bit wider than cmd_len so that a 2^BLEN_W word burst does not wrap.
    logic [BLEN_W:0]   rem_q;
    logic              busy_q;

    // Skid buffer: the head entry drives the stream and the tail entry
    // holds the second word.
    logic [1:0]        buf_cnt_q,   buf_cnt_d;
    logic [DSIZE-1:0]  head_data_q, head_data_d;
    logic              head_last_q, head_last_d;
    logic [DSIZE-1:0]  tail_data_q, tail_data_d;
    logic              tail_last_q, tail_last_d;

    logic              pop;
    logic              accept;
    logic              pop_last;

    // Pop decision uses registered state plus the FIFO flag only. Blocking on
    // buf_cnt==2 keeps the buffer from overflowing regardless of out_ready.
    assign pop      = (state_q == RUN) && !rd_empty && (rem_q != '0) &&
                      (buf_cnt_q != 2'd2);
    assign accept   = (buf_cnt_q != 2'd0) && out_ready;
    assign pop_last = (rem_q == REM_ONE);

    assign rd_inc    = pop;
    assign cmd_ready = (state_q == IDLE);
    assign out_valid = (buf_cnt_q != 2'd0);
    assign out_data  = head_data_q;
    assign out_last  = head_last_q;
    assign busy      = busy_q;

    // Skid-buffer next state.
    always_comb begin
        buf_cnt_d   = buf_cnt_q;
        head_data_d = head_data_q;
        head_last_d = head_last_q;
        tail_data_d = tail_data_q;
        tail_last_d = tail_last_q;
        case ({pop, accept})
            2'b10: begin
                // Write-only: fill the first free slot.
                if (buf_cnt_q == 2'd0) begin
                    head_data_d = rd_data;
                    head_last_d = pop_last;
                end else begin
                    tail_data_d = rd_data;
                    tail_last_d = pop_last;
                end
                buf_cnt_d = buf_cnt_q + 2'd1;
            end
            2'b01: begin
                // Read-only: shift the tail forward when one is present.
                // With a single entry the head is left as is, so no stale
                // tail data is presented.
                if (buf_cnt_q == 2'd2) begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                end
                buf_cnt_d = buf_cnt_q - 2'd1;
            end
            2'b11: begin
                // Simultaneous pop and accept: the occupancy is unchanged.
                if (buf_cnt_q == 2'd1) begin
                    head_data_d = rd_data;
                    head_last_d = pop_last;
                end else begin
                    head_data_d = tail_data_q;
                    head_last_d = tail_last_q;
                    tail_data_d = rd_data;
                    tail_last_d = pop_last;
                end
            end
            default: begin
            end
        endcase
    end

    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            buf_cnt_q   <= 2'd0;
            head_data_q <= '0;
            head_last_q <= 1'b0;
            tail_data_q <= '0;
            tail_last_q <= 1'b0;
        end else begin
            buf_cnt_q   <= buf_cnt_d;
            head_data_q <= head_data_d;
            head_last_q <= head_last_d;
            tail_data_q <= tail_data_d;
            tail_last_q <= tail_last_d;
        end
    end

    // Burst control FSM.
    always_ff @(posedge rd_clk or negedge rd_rst) begin
        if (!rd_rst) begin
            state_q <= IDLE;
            rem_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (cmd_valid) begin
                        rem_q   <= {1'b0, cmd_len} + REM_ONE;
                        state_q <= RUN;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (pop) begin
                        rem_q <= rem_q - REM_ONE;
                        if (pop_last) begin
                            state_q <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // The last-tagged word can only be the head once every
                    // earlier beat has gone, so waiting on it drains the buffer.
                    if (accept && head_last_q) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_rd_burst.sv
module tb_fifo_rd_burst;

    localparam int DSIZE  = 8;
    localparam int BLEN_W = 4;

    logic              rd_clk;
    logic              rd_rst;
    logic [DSIZE-1:0]  rd_data;
    logic              rd_empty;
    logic              rd_inc;
    logic              cmd_valid;
    logic              cmd_ready;
    logic [BLEN_W-1:0] cmd_len;
    logic              out_valid;
    logic              out_ready;
    logic [DSIZE-1:0]  out_data;
    logic              out_last;
    logic              busy;

    fifo_rd_burst #(.DSIZE(DSIZE), .BLEN_W(BLEN_W)) dut (
        .rd_clk    (rd_clk),
        .rd_rst    (rd_rst),
        .rd_data   (rd_data),
        .rd_empty  (rd_empty),
        .rd_inc    (rd_inc),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_len   (cmd_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .busy      (busy)
    );

    initial rd_clk = 1'b0;
    always #5 rd_clk = ~rd_clk;

    // Reference model state.
    logic [DSIZE-1:0] fifo[$];     // words still in the FIFO, head first
    logic [DSIZE:0]   sb[$];       // words held by the block: {last, data}
    bit               active;      // burst in progress (accept .. last beat taken)
    int               pops_left;   // words of the current burst not yet popped
    int               burst_n;
    int               beats;
    bit               stall_prev;
    logic [DSIZE-1:0] prev_data;
    logic             prev_last;
    bit               cmd_accepted;
    int               ready_mode;  // 0 hold, 1 random, 2 pattern 1,0,0,1
    int               pat_idx;

    int checks;
    int errors;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_fifo();
        rd_empty = (fifo.size() == 0);
        rd_data  = rd_empty ? 8'hEE : fifo[0];
    endtask

    task automatic push(input logic [DSIZE-1:0] w);
        fifo.push_back(w);
        drive_fifo();
    endtask

    task automatic push_rand(input int n);
        for (int i = 0; i < n; i++) push(DSIZE'($urandom));
    endtask

    task automatic model_reset();
        sb.delete();
        active     = 1'b0;
        pops_left  = 0;
        beats      = 0;
        stall_prev = 1'b0;
    endtask

    // One clock cycle. The bench samples at the falling edge, applies the
    // model effects just after the rising edge, and drives new inputs there.
    task automatic tick();
        bit pop_m, acc_m, cmd_m, lst;
        logic [DSIZE:0] ent;
        logic [DSIZE-1:0] w;
        cmd_accepted = 1'b0;
        if (ready_mode == 1) out_ready = 1'($urandom_range(0, 1));
        if (ready_mode == 2) begin
            out_ready = (pat_idx % 4 == 0) || (pat_idx % 4 == 3);
            pat_idx++;
        end
        @(negedge rd_clk);
        if (!rd_rst) begin
            chk("rst_rd_inc", 32'(rd_inc), 32'd0);
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_busy", 32'(busy), 32'd0);
            @(posedge rd_clk);
            #1;
            return;
        end
        pop_m = active && (pops_left > 0) && (fifo.size() > 0) && (sb.size() < 2);
        acc_m = (sb.size() != 0) && out_ready;
        cmd_m = !active && cmd_valid;
        chk("rd_inc", 32'(rd_inc), 32'(pop_m));
        chk("cmd_ready", 32'(cmd_ready), 32'(!active));
        chk("busy", 32'(busy), 32'(active));
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        if (stall_prev) begin
            chk("hold_data", 32'(out_data), 32'(prev_data));
            chk("hold_last", 32'(out_last), 32'(prev_last));
        end
        if (acc_m) begin
            ent = sb[0];
            chk("beat_data", 32'(out_data), 32'(ent[DSIZE-1:0]));
            chk("beat_last", 32'(out_last), 32'(ent[DSIZE]));
        end
        stall_prev = (sb.size() != 0) && !out_ready;
        prev_data  = out_data;
        prev_last  = out_last;
        @(posedge rd_clk);
        #1;
        if (acc_m) begin
            ent = sb.pop_front();
            lst = ent[DSIZE];
            beats++;
            if (lst) begin
                chk("burst_beats", 32'(beats), 32'(burst_n));
                active = 1'b0;
            end
        end
        if (pop_m) begin
            w = fifo.pop_front();
            sb.push_back({(pops_left == 1), w});
            pops_left--;
        end
        if (cmd_m) begin
            active       = 1'b1;
            burst_n      = int'(cmd_len) + 1;
            pops_left    = burst_n;
            beats        = 0;
            cmd_accepted = 1'b1;
        end
        drive_fifo();
    endtask

    task automatic wait_accept(input int max);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while (!cmd_accepted && n < max);
        chk("cmd_accept_timeout", 32'(cmd_accepted), 32'd1);
    endtask

    task automatic send_cmd(input int len);
        cmd_valid = 1'b1;
        cmd_len   = BLEN_W'(len);
        wait_accept(100);
        cmd_valid = 1'b0;
    endtask

    task automatic run_until_idle(input int max);
        int n;
        n = 0;
        while (active && n < max) begin
            tick();
            n++;
        end
        chk("idle_timeout", 32'(active), 32'd0);
    endtask

    initial begin
        checks     = 0;
        errors     = 0;
        ready_mode = 0;
        pat_idx    = 0;
        model_reset();
        rd_rst    = 1'b0;
        cmd_valid = 1'b0;
        cmd_len   = '0;
        out_ready = 1'b0;
        drive_fifo();

        // Power-on reset.
        #1;
        chk("por_out_data", 32'(out_data), 32'd0);
        chk("por_out_last", 32'(out_last), 32'd0);
        tick();
        tick();
        rd_rst = 1'b1;
        tick();

        // Basic burst: 0x11..0x14, sink always ready.
        push(8'h11); push(8'h12); push(8'h13); push(8'h14);
        out_ready = 1'b1;
        send_cmd(3);
        run_until_idle(50);
        tick();

        // Backpressure with a 1,0,0,1 ready pattern.
        push_rand(8);
        ready_mode = 2;
        send_cmd(7);
        run_until_idle(100);
        ready_mode = 0;
        out_ready  = 1'b1;

        // FIFO runs dry in the middle of a burst.
        push_rand(2);
        send_cmd(4);
        repeat (10) tick();
        push_rand(1);
        repeat (3) tick();
        push_rand(2);
        run_until_idle(50);

        // Single-word burst with 3 words present (2 stay behind).
        push_rand(3);
        send_cmd(0);
        run_until_idle(20);

        // Maximum burst of 16 words: 2 left over plus 14 new.
        push_rand(14);
        ready_mode = 1;
        send_cmd(15);
        run_until_idle(200);

        // cmd_valid held through a burst: the second command waits for IDLE.
        push_rand(7);
        cmd_valid = 1'b1;
        cmd_len   = 4'd3;
        wait_accept(20);
        cmd_len   = 4'd2;
        wait_accept(100);
        cmd_valid = 1'b0;
        run_until_idle(100);

        // Reset in the middle of a burst with the buffer full.
        ready_mode = 0;
        out_ready  = 1'b0;
        push_rand(6);
        send_cmd(5);
        repeat (4) tick();
        #3;
        rd_rst = 1'b0;
        #1;
        chk("arst_rd_inc", 32'(rd_inc), 32'd0);
        chk("arst_out_valid", 32'(out_valid), 32'd0);
        chk("arst_out_last", 32'(out_last), 32'd0);
        chk("arst_out_data", 32'(out_data), 32'd0);
        chk("arst_busy", 32'(busy), 32'd0);
        model_reset();
        tick();
        tick();
        rd_rst = 1'b1;
        ready_mode = 1;
        send_cmd(3);
        run_until_idle(100);

        // Random bursts with data arriving in pieces.
        for (int b = 0; b < 6; b++) begin
            int len;
            int first;
            len   = int'($urandom_range(0, 15));
            first = int'($urandom_range(0, len + 1));
            push_rand(first);
            send_cmd(len);
            repeat ($urandom_range(0, 6)) tick();
            push_rand(len + 1 - first);
            run_until_idle(200);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
